// File: rtl/mem_lower_pkg.sv
// Shared types and helpers for the mem_1r1w read engine.
// Geometry, FSM states, buffer entry layout and address wrap.
package mem_lower_pkg;

  localparam int DEPTH      = 48;
  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 64;
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } rd_entry_t;

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(
    input logic [ADDR_WIDTH-1:0] a
  );
    if (a == ADDR_WIDTH'(DEPTH - 1)) begin
      return '0;
    end
    return a + ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/mem_1r1w_reader_skid.sv
// Two-entry output FIFO for the read engine.
// Holds returned words until the consumer accepts them.
module mem_1r1w_reader_skid
  import mem_lower_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_last_o,
  output logic [1:0]            count_o
);

  rd_entry_t  ent_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;
  rd_entry_t  push_ent;

  assign do_pop   = pop_i && (count_q != 2'd0);
  assign do_push  = push_i && ((count_q != 2'd2) || do_pop);
  assign push_ent = '{data: push_data_i, last: push_last_i};

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        ent_q[wr_ptr_q] <= push_ent;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data_o = ent_q[rd_ptr_q].data;
  assign head_last_o = ent_q[rd_ptr_q].last;
  assign count_o     = count_q;

endmodule

// File: rtl/mem_1r1w_reader.sv
// Streaming read engine for the R0 port of a latency-1 mem_1r1w.
// Base/length command in, valid/ready word stream out.
module mem_1r1w_reader
  import mem_lower_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  cmd_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] R0_addr,
  output logic                  R0_en,
  input  logic [DATA_WIDTH-1:0] R0_data
);

  rd_state_e             state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  inflight_q;
  logic                  infl_last_q;
  logic                  err_q;

  logic       accept;
  logic       cmd_bad;
  logic       cmd_zero;
  logic       pop;
  logic       credit_ok;
  logic       issue;
  logic       last_issue;
  logic [1:0] count;
  logic [2:0] need;
  logic [2:0] avail;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign cmd_err   = err_q;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_base >= ADDR_WIDTH'(DEPTH)) ||
                     (cmd_len > LEN_WIDTH'(DEPTH));
  assign cmd_zero  = (cmd_len == '0);

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  // buffered + in-flight words after this cycle's pop must leave a slot
  assign need      = {1'b0, count} + {2'b00, inflight_q};
  assign avail     = 3'd1 + {2'b00, pop};
  assign credit_ok = (need <= avail);

  assign issue      = (state_q == RUN) && (rem_q != '0) &&
                      credit_ok && !reset;
  assign last_issue = issue && (rem_q == LEN_WIDTH'(1));

  assign R0_en   = issue;
  assign R0_addr = addr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= accept && cmd_bad;
      inflight_q  <= issue;
      infl_last_q <= last_issue;
      if (issue) begin
        addr_q <= wrap_inc(addr_q);
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (accept && !cmd_bad && !cmd_zero) begin
            addr_q  <= cmd_base;
            rem_q   <= cmd_len;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (last_issue) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_1r1w_reader_skid u_skid (
    .clock       (clock),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (R0_data),
    .push_last_i (infl_last_q),
    .pop_i       (pop),
    .head_data_o (out_data),
    .head_last_o (out_last),
    .count_o     (count)
  );

endmodule
